// File: rtl/exe_vector_stage.sv
// Vector execute stage: four parallel 8-bit pixel lanes with byte-serial WOM writeback.
// Optional WOM_BYTE_PACK_EN packs all four lane bytes into a single WOM word write.
module exe_vector_stage #(
  parameter int DATA_W = 32,
  parameter int PIX_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_pxl_in,
  input  logic              wr_wom_in,
  input  logic              alu_func_in,
  input  logic [DATA_W-1:0] pix1,
  input  logic [DATA_W-1:0] pix2,
  input  logic [DATA_W-1:0] pix3,
  input  logic [DATA_W-1:0] pix4,
  input  logic [DATA_W-1:0] cte1,
  input  logic [DATA_W-1:0] cte2,
  input  logic [DATA_W-1:0] cte3,
  input  logic [DATA_W-1:0] cte4,
  input  logic [DATA_W-1:0] wom_addr_in,
  output logic              stall,
  output logic [DATA_W-1:0] res1,
  output logic [DATA_W-1:0] res2,
  output logic [DATA_W-1:0] res3,
  output logic [DATA_W-1:0] res4,
  output logic              res_valid,
  output logic              wom_we,
  output logic [DATA_W-1:0] wom_addr,
  output logic [DATA_W-1:0] wom_data
);

  // state | meaning
  // IDLE  | no WOM write in progress, every cycle accepts
  // WRITE | emitting lane bytes to WOM, k selects lane and address offset
  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic [7:0]        r1_q, r2_q, r3_q, r4_q;
  logic              valid_q;
  logic              stall_c;
  logic              we_c;
  logic [DATA_W-1:0] addr_c;
  logic [DATA_W-1:0] data_c;
  logic              accept;

  function automatic logic [7:0] lane_op(input logic func,
                                         input logic [DATA_W-1:0] p,
                                         input logic [DATA_W-1:0] c);
    logic [8:0]  sum;
    logic [23:0] prod;
    logic [23:0] shf;
    logic [7:0]  r;
    sum  = 9'(p[PIX_W-1:0]) + 9'(c[7:0]);
    prod = 24'(p[PIX_W-1:0]) * 24'(c[15:0]);
    shf  = prod >> FRAC_W;
    if (!func) r = sum[8] ? 8'hFF : sum[7:0];
    else       r = (|shf[23:8]) ? 8'hFF : shf[7:0];
    return r;
  endfunction

  assign accept = !stall_c;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    stall_c = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    data_c  = '0;
    case (state_q)
      IDLE: begin
        if (wr_wom_in) begin
          state_d = WRITE;
          k_d     = 2'd0;
          base_d  = wom_addr_in;
        end
      end
      WRITE: begin
        we_c = 1'b1;
`ifdef WOM_BYTE_PACK_EN
        addr_c = base_q;
        data_c = DATA_W'({r4_q, r3_q, r2_q, r1_q});
        if (wr_wom_in) begin
          k_d    = 2'd0;
          base_d = wom_addr_in;
        end else begin
          state_d = IDLE;
        end
`else
        addr_c = base_q + DATA_W'(k_q);
        case (k_q)
          2'd0:    data_c = DATA_W'(r1_q);
          2'd1:    data_c = DATA_W'(r2_q);
          2'd2:    data_c = DATA_W'(r3_q);
          default: data_c = DATA_W'(r4_q);
        endcase
        stall_c = (k_q != 2'd3);
        // Last byte frees the pipe, so a following wr_wom chains with no bubble.
        if (k_q != 2'd3) begin
          k_d = k_q + 2'd1;
        end else if (wr_wom_in) begin
          k_d    = 2'd0;
          base_d = wom_addr_in;
        end else begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= 2'd0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_q    <= 8'd0;
      r2_q    <= 8'd0;
      r3_q    <= 8'd0;
      r4_q    <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= accept & wr_pxl_in;
      if (accept) begin
        r1_q <= lane_op(alu_func_in, pix1, cte1);
        r2_q <= lane_op(alu_func_in, pix2, cte2);
        r3_q <= lane_op(alu_func_in, pix3, cte3);
        r4_q <= lane_op(alu_func_in, pix4, cte4);
      end
    end
  end

  assign stall     = stall_c;
  assign wom_we    = we_c;
  assign wom_addr  = addr_c;
  assign wom_data  = data_c;
  assign res1      = DATA_W'(r1_q);
  assign res2      = DATA_W'(r2_q);
  assign res3      = DATA_W'(r3_q);
  assign res4      = DATA_W'(r4_q);
  assign res_valid = valid_q;

  logic unused_bits;
  assign unused_bits = ^{pix1[DATA_W-1:PIX_W], pix2[DATA_W-1:PIX_W],
                         pix3[DATA_W-1:PIX_W], pix4[DATA_W-1:PIX_W],
                         cte1[DATA_W-1:16], cte2[DATA_W-1:16],
                         cte3[DATA_W-1:16], cte4[DATA_W-1:16]};

endmodule

// File: tb/tb_exe_vector_stage.sv
// Randomized self-checking bench for exe_vector_stage against a queue-based WOM write model.
// Expectations follow WOM_BYTE_PACK_EN when the design is built with it.
module tb_exe_vector_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_pxl_in, wr_wom_in, alu_func_in;
  logic [31:0] pix1, pix2, pix3, pix4, cte1, cte2, cte3, cte4, wom_addr_in;
  logic        stall, res_valid, wom_we;
  logic [31:0] res1, res2, res3, res4, wom_addr, wom_data;

  exe_vector_stage dut (
    .clk(clk), .rst(rst),
    .wr_pxl_in(wr_pxl_in), .wr_wom_in(wr_wom_in), .alu_func_in(alu_func_in),
    .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4),
    .cte1(cte1), .cte2(cte2), .cte3(cte3), .cte4(cte4),
    .wom_addr_in(wom_addr_in),
    .stall(stall), .res1(res1), .res2(res2), .res3(res3), .res4(res4),
    .res_valid(res_valid), .wom_we(wom_we), .wom_addr(wom_addr), .wom_data(wom_data)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] v_pix[4];
  logic [31:0] v_cte[4];

  // Reference state: current lane results and the pending WOM writes, front = this cycle.
  logic [7:0]  m_res[4];
  bit          m_valid;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  function automatic int lane_ref(bit func, logic [31:0] p, logic [31:0] c);
    int pv, r;
    pv = int'(p & 32'hFF);
    if (!func) r = pv + int'(c & 32'hFF);
    else       r = (pv * int'(c & 32'hFFFF)) / 256;
    if (r > 255) r = 255;
    return r;
  endfunction

  function automatic logic [127:0] exp_res();
    return {24'd0, m_res[0], 24'd0, m_res[1], 24'd0, m_res[2], 24'd0, m_res[3]};
  endfunction

  task automatic model_clear();
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < 4; i++) m_res[i] = 8'd0;
    m_valid = 1'b0;
  endtask

  // Present one cycle of inputs, advance the model, and return at the next falling edge.
  task automatic drive(input bit pxl, input bit wom, input bit func, input logic [31:0] addr);
    bit acc;
    logic [31:0] dmy;
    wr_pxl_in = pxl; wr_wom_in = wom; alu_func_in = func; wom_addr_in = addr;
    pix1 = v_pix[0]; pix2 = v_pix[1]; pix3 = v_pix[2]; pix4 = v_pix[3];
    cte1 = v_cte[0]; cte2 = v_cte[1]; cte3 = v_cte[2]; cte4 = v_cte[3];
    acc = (q_addr.size() <= 1);
    if (q_addr.size() > 0) begin
      dmy = q_addr.pop_front();
      dmy = q_data.pop_front();
    end
    m_valid = acc && pxl;
    if (acc) begin
      for (int i = 0; i < 4; i++) m_res[i] = 8'(lane_ref(func, v_pix[i], v_cte[i]));
      if (wom) begin
`ifdef WOM_BYTE_PACK_EN
        q_addr.push_back(addr);
        q_data.push_back({m_res[3], m_res[2], m_res[1], m_res[0]});
`else
        for (int i = 0; i < 4; i++) begin
          q_addr.push_back(addr + 32'(i));
          q_data.push_back({24'd0, m_res[i]});
        end
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic set_lanes(input logic [31:0] p0, p1, p2, p3, c0, c1, c2, c3);
    v_pix[0] = p0; v_pix[1] = p1; v_pix[2] = p2; v_pix[3] = p3;
    v_cte[0] = c0; v_cte[1] = c1; v_cte[2] = c2; v_cte[3] = c3;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      v_pix[i] = $urandom;
      v_cte[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 511));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    wr_pxl_in = 0; wr_wom_in = 0; alu_func_in = 0; wom_addr_in = 0;
    pix1 = 0; pix2 = 0; pix3 = 0; pix4 = 0; cte1 = 0; cte2 = 0; cte3 = 0; cte4 = 0;
    model_clear();
    #3;
    tests_run++;
    if ({stall, wom_we, res_valid, wom_addr, wom_data, res1, res2, res3, res4} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: stall=%b we=%b valid=%b addr=%h data=%h res=%h/%h/%h/%h, all must be 0",
               stall, wom_we, res_valid, wom_addr, wom_data, res1, res2, res3, res4);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 32'h0);
      tests_run++;
      if ({stall, wom_we, res_valid} !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_idle[%0d]: stall=%b we=%b valid=%b, required 0/0/0", i, stall, wom_we, res_valid);
      end
    end
  endtask

  task automatic test_add();
    set_lanes(200, 10, 0, 255, 100, 20, 0, 1);
    drive(1, 0, 0, 32'h0);
    tests_run++;
    if ({res1, res2, res3, res4, res_valid} !== {32'd255, 32'd30, 32'd0, 32'd255, 1'b1}) begin
      tests_failed++;
      $display("FAIL add_sat: res=%0d/%0d/%0d/%0d valid=%b, required 255/30/0/255 valid=1",
               res1, res2, res3, res4, res_valid);
    end
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0);
    tests_run++;
    if (res_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL add_valid_pulse: res_valid=%b, required 0", res_valid);
    end
  endtask

  task automatic test_mul();
    set_lanes(128, 200, 64, 1, 32'h180, 32'h200, 32'h100, 32'h80);
    drive(1, 0, 1, 32'h0);
    tests_run++;
    if ({res1, res2, res3, res4, res_valid} !== {32'd192, 32'd255, 32'd64, 32'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL mul_q88: res=%0d/%0d/%0d/%0d valid=%b, required 192/255/64/0 valid=1",
               res1, res2, res3, res4, res_valid);
    end
  endtask

  task automatic test_random_alu();
    for (int i = 0; i < 40; i++) begin
      rand_lanes();
      drive(1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), $urandom);
      tests_run++;
      if ({res1, res2, res3, res4, res_valid} !== {exp_res(), m_valid}) begin
        tests_failed++;
        $display("FAIL alu_rand[%0d]: res=%0d/%0d/%0d/%0d valid=%b, required %0d/%0d/%0d/%0d valid=%b",
                 i, res1, res2, res3, res4, res_valid, m_res[0], m_res[1], m_res[2], m_res[3], m_valid);
      end
    end
  endtask

`ifndef WOM_BYTE_PACK_EN
  task automatic test_wom_serial();
    set_lanes(1, 2, 3, 4, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h1000);
    for (int seq = 0; seq < 2; seq++) begin
      for (int j = 0; j < 4; j++) begin
        tests_run++;
        if ({wom_we, stall, wom_addr, wom_data} !==
            {1'b1, (j < 3), (seq == 0 ? 32'h1000 : 32'h2000) + 32'(j), 32'(j + 1 + 4 * seq)}) begin
          tests_failed++;
          $display("FAIL wom_serial[%0d.%0d]: we=%b stall=%b addr=%h data=%h, required 1/%b/%h/%h",
                   seq, j, wom_we, stall, wom_addr, wom_data, (j < 3),
                   (seq == 0 ? 32'h1000 : 32'h2000) + 32'(j), 32'(j + 1 + 4 * seq));
        end
        if (j < 3) begin
          rand_lanes();
          drive(1, 1, 1'($urandom_range(0, 1)), $urandom);
        end else if (seq == 0) begin
          set_lanes(5, 6, 7, 8, 0, 0, 0, 0);
          drive(0, 1, 0, 32'h2000);
        end else begin
          set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
          drive(0, 0, 0, 32'h0);
        end
      end
    end
    tests_run++;
    if ({wom_we, stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wom_serial_end: we=%b stall=%b, required 0/0", wom_we, stall);
    end
  endtask

  task automatic test_wrap_and_reset();
    set_lanes(9, 10, 11, 12, 0, 0, 0, 0);
    drive(0, 1, 0, 32'hFFFF_FFFE);
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if ({wom_we, wom_addr, wom_data} !== {1'b1, 32'hFFFF_FFFE + 32'(j), 32'(9 + j)}) begin
        tests_failed++;
        $display("FAIL wom_wrap[%0d]: we=%b addr=%h data=%h, required 1/%h/%h",
                 j, wom_we, wom_addr, wom_data, 32'hFFFF_FFFE + 32'(j), 32'(9 + j));
      end
      set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 32'h0);
    end
    set_lanes(9, 10, 11, 12, 0, 0, 0, 0);
    drive(0, 1, 0, 32'hFFFF_FFFE);
    drive(0, 0, 0, 32'h0);
    tests_run++;
    if ({wom_we, stall, wom_addr} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
      tests_failed++;
      $display("FAIL wom_k1: we=%b stall=%b addr=%h, required 1/1/ffffffff", wom_we, stall, wom_addr);
    end
    #2 rst = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if ({wom_we, stall, wom_addr, wom_data, res1} !== '0) begin
      tests_failed++;
      $display("FAIL reset_abort: we=%b stall=%b addr=%h data=%h res1=%h, all must be 0",
               wom_we, stall, wom_addr, wom_data, res1);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 32'h0);
      tests_run++;
      if (wom_we !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_no_write[%0d]: we=%b, required 0", i, wom_we);
      end
    end
  endtask
`else
  task automatic test_pack();
    set_lanes(32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h40);
    tests_run++;
    if ({wom_we, stall, wom_addr, wom_data} !== {1'b1, 1'b0, 32'h40, 32'h4433_2211}) begin
      tests_failed++;
      $display("FAIL pack_write: we=%b stall=%b addr=%h data=%h, required 1/0/00000040/44332211",
               wom_we, stall, wom_addr, wom_data);
    end
    set_lanes(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0);
    tests_run++;
    if ({wom_we, stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL pack_single: we=%b stall=%b, required 0/0", wom_we, stall);
    end
    set_lanes(1, 2, 3, 4, 0, 0, 0, 0);
    drive(0, 1, 0, 32'hFFFF_FFFF);
    #2 rst = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if ({wom_we, stall, wom_addr, wom_data} !== '0) begin
      tests_failed++;
      $display("FAIL pack_reset: we=%b stall=%b addr=%h data=%h, all must be 0",
               wom_we, stall, wom_addr, wom_data);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask
`endif

  task automatic test_random_stream();
    bit          e_we, e_stall;
    logic [31:0] e_addr, e_data;
    for (int i = 0; i < 300; i++) begin
      rand_lanes();
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), $urandom);
      e_we    = (q_addr.size() > 0);
      e_stall = (q_addr.size() > 1);
      e_addr  = e_we ? q_addr[0] : 32'h0;
      e_data  = e_we ? q_data[0] : 32'h0;
      tests_run++;
      if ({stall, wom_we, wom_addr, wom_data, res_valid, res1, res2, res3, res4} !==
          {e_stall, e_we, e_addr, e_data, m_valid, exp_res()}) begin
        tests_failed++;
        $display("FAIL stream[%0d]: stall=%b we=%b addr=%h data=%h valid=%b res=%h/%h/%h/%h, required %b/%b/%h/%h/%b/%h/%h/%h/%h",
                 i, stall, wom_we, wom_addr, wom_data, res_valid, res1, res2, res3, res4,
                 e_stall, e_we, e_addr, e_data, m_valid, m_res[0], m_res[1], m_res[2], m_res[3]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_random_alu();
`ifndef WOM_BYTE_PACK_EN
    test_wom_serial();
    test_wrap_and_reset();
`else
    test_pack();
`endif
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
